// File: rtl/fact_pkg.sv
// Shared definitions for the factorial engine bus interface: register map,
// STATUS bit positions and FSM state encodings.
package fact_pkg;

    localparam logic [1:0] ADDR_N      = 2'd0;
    localparam logic [1:0] ADDR_GO     = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_RESULT = 2'd3;

    localparam int ST_DONE_BIT    = 0;
    localparam int ST_ERROR_BIT   = 1;
    localparam int ST_BUSY_BIT    = 2;
    localparam int ST_TIMEOUT_BIT = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LAUNCH = 2'b01,
        BUSY   = 2'b10
    } state_e;

    function automatic logic [3:0] pack_status(input logic timeout, input logic busy,
                                               input logic error, input logic done);
        logic [3:0] s;
        s                 = 4'b0000;
        s[ST_TIMEOUT_BIT] = timeout;
        s[ST_BUSY_BIT]    = busy;
        s[ST_ERROR_BIT]   = error;
        s[ST_DONE_BIT]    = done;
        return s;
    endfunction

endpackage

// File: rtl/fact_bus_if.sv
// CPU-facing register block for the factorial engine: launches the engine with
// a one-cycle GO pulse, captures its result and aborts stalled runs by watchdog.
module fact_bus_if
    import fact_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int N_WIDTH        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [1:0]            A,
    input  logic                  WE,
    input  logic [DATA_WIDTH-1:0] WD,
    output logic [DATA_WIDTH-1:0] RD,
    output logic [N_WIDTH-1:0]    n_out,
    output logic                  go_out,
    input  logic                  done_in,
    input  logic                  error_in,
    input  logic [DATA_WIDTH-1:0] result_in
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [N_WIDTH-1:0]      n_reg_q, n_reg_d;
    logic [N_WIDTH-1:0]      n_out_q, n_out_d;
    logic                    go_q, go_d;
    logic [DATA_WIDTH-1:0]   result_q, result_d;
    logic                    done_q, done_d;
    logic                    error_q, error_d;
    logic                    timeout_q, timeout_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    busy_s;
    logic                    start_s;
    logic [DATA_WIDTH-1:0]   rd_s;
    logic                    wd_unused_s;

    assign busy_s      = (state_q != IDLE);
    assign start_s     = WE && (A == ADDR_GO) && WD[0];
    assign wd_unused_s = ^WD[DATA_WIDTH-1:N_WIDTH];

    // State and register file, cleared asynchronously together with the engine
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            n_reg_q   <= '0;
            n_out_q   <= '0;
            go_q      <= 1'b0;
            result_q  <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            n_reg_q   <= n_reg_d;
            n_out_q   <= n_out_d;
            go_q      <= go_d;
            result_q  <= result_d;
            done_q    <= done_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

    // Next-state logic; N_REG stays writable while busy because n_out is a separate copy
    always_comb begin
        state_d   = state_q;
        n_out_d   = n_out_q;
        go_d      = 1'b0;
        result_d  = result_q;
        done_d    = done_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        if (WE && (A == ADDR_N)) begin
            n_reg_d = WD[N_WIDTH-1:0];
        end else begin
            n_reg_d = n_reg_q;
        end
        case (state_q)
            IDLE: begin
                if (start_s) begin
                    state_d   = LAUNCH;
                    n_out_d   = n_reg_q;
                    go_d      = 1'b1;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            LAUNCH: begin
                state_d = BUSY;
            end
            BUSY: begin
                // An engine completion on the terminal count takes priority over the watchdog
                if (done_in) begin
                    result_d = result_in;
                    error_d  = error_in;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (cnt_q == CNT_TERM) begin
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    error_d   = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read mux, combinational from the word address
    always_comb begin
        rd_s = '0;
        case (A)
            ADDR_N:      rd_s[N_WIDTH-1:0] = n_reg_q;
            ADDR_GO:     rd_s[0] = go_q;
            ADDR_STATUS: rd_s[3:0] = pack_status(timeout_q, busy_s, error_q, done_q);
            ADDR_RESULT: rd_s = result_q;
            default:     rd_s = '0;
        endcase
    end

    assign RD     = rd_s;
    assign n_out  = n_out_q;
    assign go_out = go_q;

endmodule

// File: tb/tb_fact_bus_if.sv
// Directed bench for fact_bus_if: the bench plays both CPU and engine.
module tb_fact_bus_if;
    import fact_pkg::*;

    localparam int DW = 32;
    localparam int NW = 4;
    localparam int TO = 8;

    logic          CLK = 1'b0;
    logic          RST;
    logic [1:0]    A;
    logic          WE;
    logic [DW-1:0] WD;
    logic [DW-1:0] RD;
    logic [NW-1:0] n_out;
    logic          go_out;
    logic          done_in;
    logic          error_in;
    logic [DW-1:0] result_in;

    int total = 0;
    int bad   = 0;

    fact_bus_if #(.DATA_WIDTH(DW), .N_WIDTH(NW), .TIMEOUT_CYCLES(TO)) dut (
        .CLK(CLK), .RST(RST), .A(A), .WE(WE), .WD(WD), .RD(RD),
        .n_out(n_out), .go_out(go_out), .done_in(done_in),
        .error_in(error_in), .result_in(result_in)
    );

    always #5 CLK = ~CLK;

    task automatic bus_write(input logic [1:0] a, input logic [DW-1:0] d);
        @(negedge CLK);
        A  = a;
        WD = d;
        WE = 1'b1;
        @(negedge CLK);
        WE = 1'b0;
        WD = '0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [DW-1:0] d);
        A = a;
        #1;
        d = RD;
    endtask

    task automatic engine_done(input logic err, input logic [DW-1:0] res);
        done_in   = 1'b1;
        error_in  = err;
        result_in = res;
        @(negedge CLK);
        done_in   = 1'b0;
        error_in  = 1'b0;
        result_in = '0;
    endtask

    task automatic test_reset();
        logic [DW-1:0] r;
        RST = 1'b1; A = 2'd0; WE = 1'b0; WD = '0;
        done_in = 1'b0; error_in = 1'b0; result_in = '0;
        repeat (2) @(negedge CLK);
        total++; if (go_out !== 1'b0) begin bad++; $display("FAIL rst_go: got=%0h exp=0", go_out); end
        total++; if (n_out !== 4'd0) begin bad++; $display("FAIL rst_nout: got=%0h exp=0", n_out); end
        for (int i = 0; i < 4; i++) begin
            read_reg(i[1:0], r);
            total++; if (r !== 32'd0) begin bad++; $display("FAIL rst_reg%0d: got=%0h exp=0", i, r); end
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_basic();
        logic [DW-1:0] r;
        bus_write(ADDR_N, 32'd5);
        bus_write(ADDR_GO, 32'd1);
        total++; if (go_out !== 1'b1) begin bad++; $display("FAIL basic_go_hi: got=%0h exp=1", go_out); end
        total++; if (n_out !== 4'd5) begin bad++; $display("FAIL basic_nout: got=%0h exp=5", n_out); end
        read_reg(ADDR_GO, r);
        total++; if (r !== 32'd1) begin bad++; $display("FAIL basic_go_rd: got=%0h exp=1", r); end
        @(negedge CLK);
        total++; if (go_out !== 1'b0) begin bad++; $display("FAIL basic_go_lo: got=%0h exp=0", go_out); end
        read_reg(ADDR_STATUS, r);
        total++; if (r !== 32'h4) begin bad++; $display("FAIL basic_busy: got=%0h exp=4", r); end
        engine_done(1'b0, 32'd120);
        read_reg(ADDR_STATUS, r);
        total++; if (r !== 32'h1) begin bad++; $display("FAIL basic_status: got=%0h exp=1", r); end
        read_reg(ADDR_RESULT, r);
        total++; if (r !== 32'd120) begin bad++; $display("FAIL basic_result: got=%0d exp=120", r); end
    endtask

    task automatic test_error();
        logic [DW-1:0] r;
        bus_write(ADDR_N, 32'd13);
        bus_write(ADDR_GO, 32'd1);
        total++; if (n_out !== 4'd13) begin bad++; $display("FAIL err_nout: got=%0h exp=d", n_out); end
        @(negedge CLK);
        engine_done(1'b1, 32'd0);
        read_reg(ADDR_STATUS, r);
        total++; if (r !== 32'h3) begin bad++; $display("FAIL err_status: got=%0h exp=3", r); end
        read_reg(ADDR_RESULT, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL err_result: got=%0h exp=0", r); end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] r;
        int cycles;
        bus_write(ADDR_N, 32'd3);
        bus_write(ADDR_GO, 32'd1);
        cycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            read_reg(ADDR_STATUS, r);
            if (r[ST_BUSY_BIT]) cycles++;
            else break;
        end
        total++; if (cycles !== 8) begin bad++; $display("FAIL to_cycles: got=%0d exp=8", cycles); end
        read_reg(ADDR_STATUS, r);
        total++; if (r !== 32'hB) begin bad++; $display("FAIL to_status: got=%0h exp=b", r); end
        read_reg(ADDR_RESULT, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL to_result: got=%0h exp=0", r); end
    endtask

    task automatic test_ignored();
        logic [DW-1:0] r;
        bus_write(ADDR_RESULT, 32'hFFFF_FFFF);
        bus_write(ADDR_STATUS, 32'h0000_0000);
        bus_write(ADDR_GO, 32'hFFFF_FFFE);
        total++; if (go_out !== 1'b0) begin bad++; $display("FAIL ign_go: got=%0h exp=0", go_out); end
        done_in = 1'b1; error_in = 1'b0; result_in = 32'd55;
        repeat (2) @(negedge CLK);
        done_in = 1'b0; result_in = '0;
        read_reg(ADDR_STATUS, r);
        total++; if (r !== 32'hB) begin bad++; $display("FAIL ign_status: got=%0h exp=b", r); end
        read_reg(ADDR_RESULT, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL ign_result: got=%0h exp=0", r); end
    endtask

    task automatic test_busy_writes();
        logic [DW-1:0] r;
        bus_write(ADDR_N, 32'd5);
        bus_write(ADDR_GO, 32'd1);
        bus_write(ADDR_N, 32'd7);
        total++; if (n_out !== 4'd5) begin bad++; $display("FAIL bw_nout1: got=%0h exp=5", n_out); end
        bus_write(ADDR_GO, 32'd1);
        total++; if (go_out !== 1'b0) begin bad++; $display("FAIL bw_go: got=%0h exp=0", go_out); end
        read_reg(ADDR_STATUS, r);
        total++; if (r !== 32'h4) begin bad++; $display("FAIL bw_status: got=%0h exp=4", r); end
        read_reg(ADDR_N, r);
        total++; if (r !== 32'd7) begin bad++; $display("FAIL bw_nreg: got=%0h exp=7", r); end
        total++; if (n_out !== 4'd5) begin bad++; $display("FAIL bw_nout2: got=%0h exp=5", n_out); end
        engine_done(1'b0, 32'd120);
        bus_write(ADDR_GO, 32'd1);
        total++; if (go_out !== 1'b1) begin bad++; $display("FAIL bw_go2: got=%0h exp=1", go_out); end
        total++; if (n_out !== 4'd7) begin bad++; $display("FAIL bw_nout3: got=%0h exp=7", n_out); end
        @(negedge CLK);
        engine_done(1'b0, 32'd5040);
        read_reg(ADDR_RESULT, r);
        total++; if (r !== 32'd5040) begin bad++; $display("FAIL bw_result: got=%0d exp=5040", r); end
    endtask

    task automatic test_terminal();
        logic [DW-1:0] r;
        bus_write(ADDR_N, 32'd2);
        bus_write(ADDR_GO, 32'd1);
        repeat (8) @(negedge CLK);
        read_reg(ADDR_STATUS, r);
        total++; if (r !== 32'h4) begin bad++; $display("FAIL term_busy: got=%0h exp=4", r); end
        engine_done(1'b0, 32'd2);
        read_reg(ADDR_STATUS, r);
        total++; if (r !== 32'h1) begin bad++; $display("FAIL term_status: got=%0h exp=1", r); end
        read_reg(ADDR_RESULT, r);
        total++; if (r !== 32'd2) begin bad++; $display("FAIL term_result: got=%0d exp=2", r); end
    endtask

    task automatic test_reset_mid_busy();
        logic [DW-1:0] r;
        bus_write(ADDR_N, 32'd5);
        bus_write(ADDR_GO, 32'd1);
        repeat (3) @(negedge CLK);
        #2;
        RST = 1'b1;
        #1;
        total++; if (go_out !== 1'b0) begin bad++; $display("FAIL mrst_go: got=%0h exp=0", go_out); end
        total++; if (n_out !== 4'd0) begin bad++; $display("FAIL mrst_nout: got=%0h exp=0", n_out); end
        read_reg(ADDR_N, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL mrst_nreg: got=%0h exp=0", r); end
        read_reg(ADDR_STATUS, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL mrst_status: got=%0h exp=0", r); end
        read_reg(ADDR_RESULT, r);
        total++; if (r !== 32'd0) begin bad++; $display("FAIL mrst_result: got=%0h exp=0", r); end
        @(negedge CLK);
        RST = 1'b0;
        bus_write(ADDR_N, 32'd5);
        bus_write(ADDR_GO, 32'd1);
        total++; if (go_out !== 1'b1) begin bad++; $display("FAIL mrst_go2: got=%0h exp=1", go_out); end
        @(negedge CLK);
        engine_done(1'b0, 32'd120);
        read_reg(ADDR_STATUS, r);
        total++; if (r !== 32'h1) begin bad++; $display("FAIL mrst_status2: got=%0h exp=1", r); end
        read_reg(ADDR_RESULT, r);
        total++; if (r !== 32'd120) begin bad++; $display("FAIL mrst_result2: got=%0d exp=120", r); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_error();
        test_timeout();
        test_ignored();
        test_busy_writes();
        test_terminal();
        test_reset_mid_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fact_bus_if.md
Name: fact_bus_if

Overview:
Memory-mapped bus interface that sits directly upstream of the factorial control unit and its datapath.
- Accepts CPU word writes of the operand and start command, and drives a one-cycle GO pulse plus a stable operand into the engine.
- Captures the engine's done, error and result into software-readable registers.
- Adds a BUSY-phase watchdog so software can never hang on a stalled engine.

Parameters:
DATA_WIDTH, 32, bus data and result width
N_WIDTH, 4, operand width driven to engine
TIMEOUT_CYCLES, 255, max BUSY cycles before watchdog abort (must be >= 2)

Ports:
CLK  input  1  system clock, rising-edge
RST  input  1  asynchronous active-high reset
A  input  2  word address (bus addr[3:2])
WE  input  1  write enable, valid for one cycle per write
WD  input  DATA_WIDTH  write data
RD  output  DATA_WIDTH  read data, combinational from A
n_out  output  N_WIDTH  operand to engine, stable from LAUNCH until return to IDLE
go_out  output  1  one-cycle start pulse to engine GO
done_in  input  1  engine done (level, sampled each cycle)
error_in  input  1  engine error, valid when done_in=1
result_in  input  DATA_WIDTH  engine result, valid when done_in=1

Behaviour:
Register map:
- A=0: N_REG, RW, bits[N_WIDTH-1:0]; upper bits read 0.
- A=1: GO_REG, W: bit0=1 requests start; read returns {0..., go_out}.
- A=2: STATUS, RO, bits {3:timeout, 2:busy, 1:error, 0:done}.
- A=3: RESULT, RO.

Reset (async, RST=1): state=IDLE; N_REG, n_out, go_out, RESULT, done, error, timeout and the watchdog counter all 0.

FSM, registered state:
- IDLE: WE and A=1 and WD[0]=1 -> LAUNCH. On that edge: n_out<=N_REG; done, error, timeout<=0; counter<=0.
- LAUNCH: go_out=1 for exactly this one cycle -> BUSY.
- BUSY, done_in=1: RESULT<=result_in, error<=error_in, done<=1 -> IDLE.
- BUSY, done_in=0 and counter==TIMEOUT_CYCLES-1: timeout<=1, done<=1, error<=1, RESULT unchanged -> IDLE.
- BUSY otherwise: counter+1.

Timing:
- go_out, n_out and the status flags are registered.
- busy = (state != IDLE), combinational.
- Latency from start write to go_out high: 1 cycle.
- Earliest done capture: 2 cycles after go_out for the engine's S1->S2 path.

Boundary conditions:
- Start write in LAUNCH or BUSY: ignored; no state or flag change.
- N_REG write while busy: N_REG updates, n_out does not change until the next launch.
- done_in in the same cycle as the timeout terminal count: done_in wins; no timeout.
- done_in high while IDLE or LAUNCH: ignored.
- WD[0]=0 write to A=1: no effect.
- Writes to A=2 or A=3: no effect.
- Done, error and timeout are sticky until the next accepted start or reset.
- RST mid-BUSY: immediate IDLE with all cleared; the engine shares RST.

Decomposition:
- Shared package fact_pkg: address constants (ADDR_N=0, ADDR_GO=1, ADDR_STATUS=2, ADDR_RESULT=3), STATUS bit indices, and state encodings (IDLE=2'b00, LAUNCH=2'b01, BUSY=2'b10).
- Single module; the watchdog counter is inline, with width $clog2(TIMEOUT_CYCLES).
- No sub-module required.

Test Plan:
1. Write N=5, write GO=1; engine model returns 120 with done_in → go_out high exactly 1 cycle after the write; n_out=5; RESULT=120; STATUS=4'b0001.
2. Engine model raises done_in with error_in=1 (N=13) → STATUS=4'b0011; RESULT keeps its previous value if the model drives 0? No: RESULT captures result_in as driven.
3. Engine never asserts done_in, TIMEOUT_CYCLES=8 → BUSY for exactly 8 cycles, then STATUS=4'b1011.
4. Second GO write and N=7 write during BUSY → single go_out pulse only; n_out stays 5; next launch drives n_out=7.
5. done_in asserted on the terminal-count cycle → STATUS=4'b0001; timeout bit = 0.
6. RST pulsed mid-BUSY → all outputs 0 asynchronously; a new start after reset completes normally with 120.
